// File: rtl/roll_uart_rx.sv
//==============================================================================
// Module      : roll_uart_rx
// Description : UART receiver for the die-roll stream (8N1, or 8E1 when
//               ROLL_RX_PARITY_EN is defined) with valid/ack handshake.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module roll_uart_rx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_rx,
  input  logic       i_ack,
  output logic [7:0] o_data,
  output logic [4:0] o_roll,
  output logic       o_valid,
  output logic       o_frame_err,
  output logic       o_overrun,
  output logic       o_busy
);

  localparam int c_cnt_w = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [c_cnt_w-1:0] c_half = c_cnt_w'(CLKS_PER_BIT / 2);
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(CLKS_PER_BIT - 1);

`ifdef ROLL_RX_PARITY_EN
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd4
  } state_t;
`endif

  state_t               r_state;
  logic                 r_rx_meta;
  logic                 r_rx_sync;
  logic [c_cnt_w-1:0]   r_cnt;
  logic [2:0]           r_bitcnt;
  logic [7:0]           r_shift;
  logic [7:0]           r_data;
  logic                 r_valid;
  logic                 r_frame_err;
  logic                 r_overrun;
  logic                 r_busy;
  logic                 r_break;
  logic                 w_stop_ok;
`ifdef ROLL_RX_PARITY_EN
  logic                 r_par_err;

  assign w_stop_ok = r_rx_sync && !r_par_err;
`else
  assign w_stop_ok = r_rx_sync;
`endif

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state     <= ST_IDLE;
      r_rx_meta   <= 1'b1;
      r_rx_sync   <= 1'b1;
      r_cnt       <= '0;
      r_bitcnt    <= '0;
      r_shift     <= '0;
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
      r_busy      <= 1'b0;
      r_break     <= 1'b0;
`ifdef ROLL_RX_PARITY_EN
      r_par_err   <= 1'b0;
`endif
    end else begin
      r_rx_meta   <= i_rx;
      r_rx_sync   <= r_rx_meta;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
      // A byte landing in the ack cycle overrides this clear further down
      if (i_ack) r_valid <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          r_cnt    <= '0;
          r_bitcnt <= '0;
          // After a framing error the line must go high before a new start counts
          if (r_break) begin
            if (r_rx_sync) r_break <= 1'b0;
          end else if (!r_rx_sync) begin
            r_state <= ST_START;
            r_busy  <= 1'b1;
          end
        end
        ST_START: begin
          if (r_cnt == c_half) begin
            r_cnt <= '0;
            if (r_rx_sync) begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_state <= ST_DATA;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (r_cnt == c_last) begin
            r_cnt    <= '0;
            r_shift  <= {r_rx_sync, r_shift[7:1]};
            r_bitcnt <= r_bitcnt + 1'b1;
            if (r_bitcnt == 3'd7) begin
`ifdef ROLL_RX_PARITY_EN
              r_state <= ST_PARITY;
`else
              r_state <= ST_STOP;
`endif
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
`ifdef ROLL_RX_PARITY_EN
        ST_PARITY: begin
          if (r_cnt == c_last) begin
            r_cnt     <= '0;
            r_par_err <= ^{r_shift, r_rx_sync};
            r_state   <= ST_STOP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
`endif
        ST_STOP: begin
          if (r_cnt == c_last) begin
            r_cnt   <= '0;
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            if (w_stop_ok) begin
              if (r_valid && !i_ack) begin
                r_overrun <= 1'b1;
              end else begin
                r_data  <= r_shift;
                r_valid <= 1'b1;
              end
            end else begin
              r_frame_err <= 1'b1;
              r_break     <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_data      = r_data;
  assign o_roll      = r_data[4:0];
  assign o_valid     = r_valid;
  assign o_frame_err = r_frame_err;
  assign o_overrun   = r_overrun;
  assign o_busy      = r_busy;

endmodule

`default_nettype wire
